// File: rtl/booth_pkg.sv
// Shared types and encodings for the radix-2 Booth multiplier controller.
// Holds the FSM state enum, the add/sub direction codes and the {q_lsb, qm1} pair codes.
package booth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EXAMINE,
        ALU,
        SHIFT,
        DUMP,
        DONE
    } booth_state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

    // Booth pairs are {current multiplier bit, previous multiplier bit}.
    localparam logic [1:0] PAIR_SUB = 2'b10;
    localparam logic [1:0] PAIR_ADD = 2'b01;

endpackage

// File: rtl/booth_iter_counter.sv
// Iteration counter for the Booth controller: loads REG_WIDTH, counts down once per shift,
// and flags the final iteration while cnt is still 1.
module booth_iter_counter
    import booth_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int CNT_W     = $clog2(REG_WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    // The zero guard keeps the counter from wrapping even if dec were misused.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(REG_WIDTH);
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/booth_controller.sv
// Sequencing FSM for the radix-2 Booth multiplier: loads operands, runs REG_WIDTH
// examine/add-sub/shift iterations on the A/Q/M datapath, then dumps A:Q and pulses done.
module booth_controller
    import booth_pkg::*;
#(
    parameter int  REG_WIDTH = 8,
    localparam int CNT_W     = $clog2(REG_WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic q_lsb,
    output logic load_m,
    output logic load_q,
    output logic clr_a,
    output logic alu_en,
    output logic alu_sub,
    output logic shr,
    output logic dump,
    output logic busy,
    output logic done
);

    // Handshake: start is a request taken only while idle (busy=0) and is otherwise
    // dropped, never queued; done is a single-cycle pulse with no backpressure, and busy
    // stays high from LOAD through DONE, so back-to-back jobs always see one idle cycle.

    booth_state_t state;
    logic         qm1;
    logic         sub_r;
    logic         last;
    logic [1:0]   pair;

    assign pair    = {q_lsb, qm1};
    assign alu_sub = sub_r;

    booth_iter_counter #(
        .REG_WIDTH (REG_WIDTH),
        .CNT_W     (CNT_W)
    ) u_iter_counter (
        .clk  (clk),
        .rst  (rst),
        .load (state == LOAD),
        .dec  (state == SHIFT),
        .last (last)
    );

    // Outputs are registered alongside the next state, so each strobe is high exactly
    // while the FSM sits in the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            qm1    <= 1'b0;
            sub_r  <= ALU_ADD;
            load_m <= 1'b0;
            load_q <= 1'b0;
            clr_a  <= 1'b0;
            alu_en <= 1'b0;
            shr    <= 1'b0;
            dump   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            load_m <= 1'b0;
            load_q <= 1'b0;
            clr_a  <= 1'b0;
            alu_en <= 1'b0;
            shr    <= 1'b0;
            dump   <= 1'b0;
            done   <= 1'b0;
            sub_r  <= ALU_ADD;
            busy   <= 1'b1;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LOAD;
                        load_m <= 1'b1;
                        load_q <= 1'b1;
                        clr_a  <= 1'b1;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                LOAD: begin
                    qm1   <= 1'b0;
                    state <= EXAMINE;
                end
                EXAMINE: begin
                    case (pair)
                        PAIR_SUB: begin
                            state  <= ALU;
                            alu_en <= 1'b1;
                            sub_r  <= ALU_SUB;
                        end
                        PAIR_ADD: begin
                            state  <= ALU;
                            alu_en <= 1'b1;
                            sub_r  <= ALU_ADD;
                        end
                        default: begin
                            state <= SHIFT;
                            shr   <= 1'b1;
                        end
                    endcase
                end
                ALU: begin
                    state <= SHIFT;
                    shr   <= 1'b1;
                end
                SHIFT: begin
                    // q_lsb is still the pre-shift bit here; it becomes the next Q(-1).
                    qm1 <= q_lsb;
                    if (last) begin
                        state <= DUMP;
                        dump  <= 1'b1;
                    end else begin
                        state <= EXAMINE;
                    end
                end
                DUMP: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: an A/Q/M datapath model driven by the DUT strobes, a Booth
// recoding reference queued per job, and a negedge monitor that scores every cycle.
module tb_booth_controller;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic q_lsb;
    logic load_m, load_q, clr_a, alu_en, alu_sub, shr, dump, busy, done;

    int tests  = 0;
    int failed = 0;

    logic [W-1:0] cur_mcand = '0;
    logic [W-1:0] cur_mplier = '0;

    logic [W-1:0]   exp_alu_q[$];
    logic [W-1:0]   exp_sub_q[$];
    logic [31:0]    exp_lat_q[$];
    logic [2*W-1:0] exp_prod_q[$];

    logic [W:0]     a_reg = '0;
    logic [W-1:0]   q_reg = '0;
    logic [W-1:0]   m_reg = '0;
    logic [2*W-1:0] prod_reg = '0;

    booth_controller #(.REG_WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .q_lsb   (q_lsb),
        .load_m  (load_m),
        .load_q  (load_q),
        .clr_a   (clr_a),
        .alu_en  (alu_en),
        .alu_sub (alu_sub),
        .shr     (shr),
        .dump    (dump),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Datapath model: A is one bit wider so M = -2^(W-1) cannot overflow the accumulator.
    always @(posedge clk) begin
        if (load_m) m_reg <= cur_mcand;
        if (load_q) q_reg <= cur_mplier;
        if (clr_a)  a_reg <= '0;
        if (alu_en) a_reg <= alu_sub ? a_reg - {m_reg[W-1], m_reg} : a_reg + {m_reg[W-1], m_reg};
        if (shr) begin
            a_reg <= {a_reg[W], a_reg[W:1]};
            q_reg <= {a_reg[0], q_reg[W-1:1]};
        end
        if (dump) prod_reg <= {a_reg[W-1:0], q_reg};
    end

    assign q_lsb = q_reg[0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: Booth recoding over pairs {m[i], m[i-1]} with m[-1] = 0.
    task automatic push_exp(input logic [W-1:0] mc, input logic [W-1:0] mp);
        logic [W-1:0] prev;
        logic [W-1:0] alu_mask;
        int           p;
        prev     = {mp[W-2:0], 1'b0};
        alu_mask = mp ^ prev;
        p        = int'($signed(mc)) * int'($signed(mp));
        exp_alu_q.push_back(alu_mask);
        exp_sub_q.push_back(mp & ~prev);
        exp_lat_q.push_back(32'(3 + 2 * W + $countones(alu_mask)));
        exp_prod_q.push_back(p[2*W-1:0]);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_wait_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mp);
        wait_idle();
        cur_mcand  = mc;
        cur_mplier = mp;
        push_exp(mc, mp);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Monitor: observes one cycle per negedge and scores each job at its done pulse.
    initial begin
        bit           in_txn;
        bit           pend_alu;
        bit           prev_done;
        bit           prev_dump;
        int           rel;
        int           iter;
        int           shr_cnt;
        logic [W-1:0] obs_alu;
        logic [W-1:0] obs_sub;
        logic [W-1:0]   e_alu;
        logic [W-1:0]   e_sub;
        logic [31:0]    e_lat;
        logic [2*W-1:0] e_prod;
        in_txn = 0; pend_alu = 0; prev_done = 0; prev_dump = 0;
        rel = 0; iter = 0; shr_cnt = 0; obs_alu = '0; obs_sub = '0;
        e_alu = '0; e_sub = '0; e_lat = '0; e_prod = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_txn = 0; pend_alu = 0; prev_done = 0; prev_dump = 0;
                continue;
            end
            check("strobe_onehot", 32'($countones({load_m, alu_en, shr, dump}) <= 1), 32'd1);
            check("load_group", 32'({load_q, clr_a}), 32'({load_m, load_m}));
            if (prev_done) check("idle_gap_after_done", 32'(load_m), 32'd0);
            if (pend_alu)  check("alu_then_shr", 32'(shr), 32'd1);
            if (load_m) begin
                check("load_expected", 32'(!in_txn && exp_lat_q.size() != 0), 32'd1);
                if (!in_txn && exp_lat_q.size() != 0) begin
                    e_alu  = exp_alu_q.pop_front();
                    e_sub  = exp_sub_q.pop_front();
                    e_lat  = exp_lat_q.pop_front();
                    e_prod = exp_prod_q.pop_front();
                    in_txn = 1; rel = 1; iter = 0; shr_cnt = 0;
                    obs_alu = '0; obs_sub = '0;
                end
            end else if (in_txn) begin
                rel++;
            end
            check("busy", 32'(busy), 32'(in_txn));
            if (alu_en && in_txn && iter < W) begin
                obs_alu[iter] = 1'b1;
                obs_sub[iter] = alu_sub;
            end
            pend_alu = alu_en;
            if (shr) begin
                iter++;
                shr_cnt++;
            end
            if (done) begin
                check("done_in_job", 32'(in_txn), 32'd1);
                if (in_txn) begin
                    check("done_latency", 32'(rel), e_lat);
                    check("alu_iterations", 32'(obs_alu), 32'(e_alu));
                    check("alu_directions", 32'(obs_sub), 32'(e_sub));
                    check("shr_count", 32'(shr_cnt), 32'(W));
                    check("dump_before_done", 32'(prev_dump), 32'd1);
                    check("product", 32'(prod_reg), 32'(e_prod));
                end
                in_txn = 0;
            end
            prev_dump = dump;
            prev_done = done;
        end
    end

    // Driver.
    initial begin
        int loads;
        int shrs;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 32'({load_m, load_q, clr_a, alu_en, alu_sub, shr, dump, done}), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        run_op(8'h5A, 8'h00);
        run_op(8'h13, 8'h01);
        run_op(8'hE7, 8'h55);
        run_op(8'h7F, 8'hFF);
        run_op(8'h80, 8'h80);

        // Reset in the cycle after the third shift, then a clean job.
        run_op(8'h21, 8'h6C);
        shrs = 0;
        for (int i = 0; i < 100 && shrs < 3; i++) begin
            if (shr) shrs++;
            if (shrs < 3) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midop_reset_outputs", 32'({load_m, load_q, clr_a, alu_en, alu_sub, shr, dump, done}), 32'd0);
        check("midop_reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        run_op(8'hC3, 8'h3B);

        // start held high: exactly two jobs, each separated by an idle cycle.
        wait_idle();
        cur_mcand  = 8'h35;
        cur_mplier = 8'hA6;
        push_exp(cur_mcand, cur_mplier);
        push_exp(cur_mcand, cur_mplier);
        start = 1'b1;
        loads = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (load_m) loads++;
            if (loads == 2) break;
        end
        start = 1'b0;

        // start pulsed during SHIFT and DONE must be ignored.
        run_op(8'h9D, 8'h4E);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            start = shr | done;
            if (done) begin
                @(posedge clk);
                #1;
                start = 1'b0;
                break;
            end
        end

        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
        end

        wait_idle();
        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_lat_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", failed, tests);
        $fatal(1, "watchdog");
    end

endmodule
